// File: rtl/ext_bus_pkg.sv
// Shared types and defaults for the FPGA-to-HPS external master initiator.
package ext_bus_pkg;

    localparam int EXT_BUS_ADDR_W = 12;
    localparam int EXT_BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Response as seen by user logic; also used by bench monitors.
    typedef struct packed {
        logic [EXT_BUS_DATA_W-1:0] rdata;
        logic                      write;
        logic                      timeout;
    } rsp_t;

endpackage

// File: rtl/ext_bus_initiator_if.sv
// Command, response and bridge-side signals of one external master initiator.
// The "master" modport is the initiator's view; "slave" is the environment's.
interface ext_bus_initiator_if
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W = EXT_BUS_ADDR_W,
    parameter int DATA_W = EXT_BUS_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BE_W-1:0]   cmd_be;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_write;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] bus_address;
    logic [BE_W-1:0]   bus_byte_enable;
    logic              bus_read;
    logic              bus_write;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_acknowledge;
    logic [DATA_W-1:0] bus_read_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
        input  rsp_ready, bus_acknowledge, bus_read_data,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout,
        output bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
        output rsp_ready, bus_acknowledge, bus_read_data,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout,
        input  bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data
    );

endinterface

// File: rtl/ext_bus_initiator_timeout_ctr.sv
// Acknowledge-wait counter: counts enabled cycles, clears on request, and
// flags the last permitted cycle. TIMEOUT_CYCLES = 0 never flags.
// TIMEOUT_CYCLES must be below 2**TO_W.
module ext_bus_timeout_ctr #(
    parameter int TO_W           = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic            TC_EN  = (TIMEOUT_CYCLES != 0);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    // Next count: clear wins, otherwise count up without wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {TO_W{1'b0}};
        end else if (en && (count_q != {TO_W{1'b1}})) begin
            count_d = count_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {TO_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = TC_EN && en && (count_q == TC_VAL);

endmodule

// File: rtl/ext_bus_initiator.sv
// Fabric-side initiator for one FPGA-to-HPS external master bridge port.
// One command in flight: IDLE accepts, REQ holds a strobe until acknowledge
// or timeout, RESP presents the response until consumed.
// Optional: define EXT_BUS_INITIATOR_STATS_EN to add transaction/timeout
// statistics counters with a synchronous stat_clear input.
module ext_bus_initiator
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W         = EXT_BUS_ADDR_W,
    parameter int DATA_W         = EXT_BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    ext_bus_initiator_if.master        bus_if
`ifdef EXT_BUS_INITIATOR_STATS_EN
    ,
    input  logic                       stat_clear,
    output logic [31:0]                stat_txn_count,
    output logic [15:0]                stat_timeout_count
`endif
);
    localparam int BE_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bus_address_q, bus_address_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              tc_s;
    logic              rsp_done_s;

    assign rsp_done_s = (state_q == RESP) && bus_if.rsp_ready;

    ext_bus_timeout_ctr #(
        .TO_W          (TO_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk  (clk),
        .reset(reset),
        .clr  (rsp_done_s),
        .en   (state_q == REQ),
        .tc   (tc_s)
    );

    // Next state and next register values; acknowledge beats timeout.
    always_comb begin
        state_d       = state_q;
        bus_address_d = bus_address_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_write_d   = rsp_write_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (bus_if.cmd_valid) begin
                    bus_address_d = bus_if.cmd_addr;
                    bus_be_d      = bus_if.cmd_be;
                    bus_wdata_d   = bus_if.cmd_wdata;
                    bus_read_d    = !bus_if.cmd_write;
                    bus_write_d   = bus_if.cmd_write;
                    rsp_write_d   = bus_if.cmd_write;
                    state_d       = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_if.bus_acknowledge) begin
                    bus_read_d    = 1'b0;
                    bus_write_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    if (bus_write_q) begin
                        rsp_rdata_d = {DATA_W{1'b0}};
                    end else begin
                        rsp_rdata_d = bus_if.bus_read_data;
                    end
                    state_d = RESP;
                end else if (tc_s) begin
                    bus_read_d    = 1'b0;
                    bus_write_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = {DATA_W{1'b0}};
                    state_d       = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (bus_if.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                bus_read_d  = 1'b0;
                bus_write_d = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops strobes and any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bus_address_q <= {ADDR_W{1'b0}};
            bus_be_q      <= {BE_W{1'b0}};
            bus_wdata_q   <= {DATA_W{1'b0}};
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_W{1'b0}};
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_address_q <= bus_address_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_write_q   <= rsp_write_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus_if.cmd_ready       = (state_q == IDLE) && !reset;
    assign bus_if.rsp_valid       = rsp_valid_q;
    assign bus_if.rsp_rdata       = rsp_rdata_q;
    assign bus_if.rsp_write       = rsp_write_q;
    assign bus_if.rsp_timeout     = rsp_timeout_q;
    assign bus_if.bus_address     = bus_address_q;
    assign bus_if.bus_byte_enable = bus_be_q;
    assign bus_if.bus_read        = bus_read_q;
    assign bus_if.bus_write       = bus_write_q;
    assign bus_if.bus_write_data  = bus_wdata_q;

`ifdef EXT_BUS_INITIATOR_STATS_EN
    logic [31:0] stat_txn_q, stat_txn_d;
    logic [15:0] stat_to_q, stat_to_d;

    // Statistics update: clear has priority over counting a handshake.
    always_comb begin
        stat_txn_d = stat_txn_q;
        stat_to_d  = stat_to_q;
        if (stat_clear) begin
            stat_txn_d = 32'd0;
            stat_to_d  = 16'd0;
        end else if (rsp_done_s) begin
            stat_txn_d = stat_txn_q + 32'd1;
            if (rsp_timeout_q) begin
                stat_to_d = stat_to_q + 16'd1;
            end else begin
                stat_to_d = stat_to_q;
            end
        end else begin
            stat_txn_d = stat_txn_q;
            stat_to_d  = stat_to_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_txn_q <= 32'd0;
            stat_to_q  <= 16'd0;
        end else begin
            stat_txn_q <= stat_txn_d;
            stat_to_q  <= stat_to_d;
        end
    end

    assign stat_txn_count     = stat_txn_q;
    assign stat_timeout_count = stat_to_q;
`endif

endmodule
